// File: rtl/main_decoder_pkg.sv
// main_decoder_pkg: opcodes, aluop classes and controller state encoding
package main_decoder_pkg;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation classes, shared with the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX,
        RTYPEWB, BEQEX, ADDIEX, ADDIWB, ORIEX, ORIWB, JEX
    } state_t;

endpackage

// File: rtl/main_decoder.sv
// main_decoder: multicycle Moore control FSM for the MIPS-style datapath
module main_decoder
    import main_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic [1:0] aluop,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       pcwrite,
    output logic       branch,
    output logic       pcen
);

    state_t state, state_next;

    // State register; reset drops straight back to FETCH mid-instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Next state; op only matters in DECODE and MEMADR, stray encodings recover to FETCH
    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:   state_next = DECODE;
            DECODE:
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = RTYPEEX;
                    OP_BEQ:       state_next = BEQEX;
                    OP_ADDI:      state_next = ADDIEX;
                    OP_ORI:       state_next = ORIEX;
                    OP_J:         state_next = JEX;
                    default:      state_next = FETCH;
                endcase
            MEMADR:  state_next = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_next = MEMWB;
            RTYPEEX: state_next = RTYPEWB;
            ADDIEX:  state_next = ADDIWB;
            ORIEX:   state_next = ORIWB;
            default: state_next = FETCH;
        endcase
    end

    // Moore output decode; anything not set for a state stays 0
    always_comb begin
        aluop    = ALUOP_ADD;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        iord     = 1'b0;
        irwrite  = 1'b0;
        memwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        case (state)
            FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
            end
            DECODE: alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIWB, ORIWB: regwrite = 1'b1;
            ORIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = ALUOP_OR;
            end
            JEX: begin
                pcwrite = 1'b1;
                pcsrc   = 2'b10;
            end
            default: ;
        endcase
    end

    assign pcen = pcwrite | (branch & zero);

endmodule

// File: doc/main_decoder.md
MAIN_DECODER -- requirements
Module: main_decoder

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op  input  6  opcode field of the instruction register.
REQ-005 zero  input  1  ALU zero flag from datapath.
REQ-006 aluop  output  2  ALU operation class to ALU decoder: 00 add, 01 sub, 10 use funct, 11 or.
REQ-007 alusrca  output  1  0 = PC, 1 = register A.
REQ-008 alusrcb  output  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
REQ-009 pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-010 iord, irwrite, memwrite, regdst, memtoreg, regwrite  output  1 each  datapath strobes and muxes.
REQ-011 pcwrite, branch  output  1 each  unconditional PC write and branch qualifier.
REQ-012 pcen  output  1  PC enable, equal to pcwrite OR (branch AND zero).

Function
REQ-013 The block SHALL be a Moore FSM; every output except pcen SHALL depend only on the current state.
REQ-014 pcen SHALL be combinational from the current state and zero, with zero cycles of latency.
REQ-015 The states SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, ORIEX, ORIWB and JEX.
REQ-016 State transitions SHALL be as follows.
- FETCH goes to DECODE.
- DECODE goes by op to:
  - MEMADR for lw (100011) or sw (101011);
  - RTYPEEX for 000000;
  - BEQEX for 000100;
  - ADDIEX for 001000;
  - ORIEX for 001101;
  - JEX for 000010.
- MEMADR goes to MEMRD for lw and to MEMWR for sw.
- MEMRD goes to MEMWB.
- RTYPEEX goes to RTYPEWB.
- ADDIEX goes to ADDIWB.
- ORIEX goes to ORIWB.
- MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, ORIWB and JEX all go to FETCH.
REQ-017 In DECODE, an undefined op SHALL go to FETCH, so the instruction executes as a 2-cycle NOP with no register or memory write.
REQ-018 Any unreachable state encoding SHALL go to FETCH on the next edge.
REQ-019 Outputs not listed for a state SHALL be 0.
- FETCH: irwrite=1, pcwrite=1, alusrcb=01.
- DECODE: alusrcb=11.
- MEMADR and ADDIEX: alusrca=1, alusrcb=10.
- MEMRD: iord=1.
- MEMWB: regwrite=1, memtoreg=1.
- MEMWR: iord=1, memwrite=1.
- RTYPEEX: alusrca=1, aluop=10.
- RTYPEWB: regwrite=1, regdst=1.
- BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIWB and ORIWB: regwrite=1.
- ORIEX: alusrca=1, alusrcb=10, aluop=11.
- JEX: pcwrite=1, pcsrc=10.
REQ-020 Instruction latencies in cycles SHALL be: lw 5, sw 4, R-type 4, addi 4, ori 4, beq 3, j 3.
REQ-021 op SHALL be sampled only in DECODE and MEMADR; op changes in other states SHALL have no effect.

Reset
REQ-022 Asserting reset SHALL force state to FETCH immediately, regardless of clk, including mid-instruction.
REQ-023 During reset, outputs SHALL equal the FETCH values: irwrite=1, pcwrite=1, pcen=1, alusrcb=01, all others 0.
REQ-024 On the first rising edge after reset deasserts, the state SHALL advance to DECODE.

Structure
REQ-025 The opcode constants, the aluop encodings (shared with the ALU decoder) and the state encoding SHALL live in a shared package or include file.
REQ-026 The block SHALL be a single module with no sub-modules.
REQ-027 The block SHALL be instantiated alongside the ALU decoder in the controller.
REQ-028 The next-state logic, the state register and the output decode SHALL be separate processes.

Verification
REQ-029 lw: reset, release, op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-030 sw: op=101011 -> memwrite=1 and iord=1 for exactly one cycle (cycle 4), then FETCH; regwrite never 1.
REQ-031 beq: op=000100 with zero=1 -> pcen=1 in BEQEX; with zero=0 -> pcen=0 in BEQEX; aluop=01 in both cases.
REQ-032 ori and R-type: op=001101 -> aluop=11 in ORIEX, then regwrite=1 with regdst=0; op=000000 -> aluop=10, then regwrite=1 with regdst=1.
REQ-033 Undefined op: op=111111 -> DECODE, then FETCH; no write strobes asserted.
REQ-034 Async reset: assert reset between edges while in MEMRD -> state FETCH and irwrite=1 before the next edge.
